// File: rtl/fir_pkg.sv
`default_nettype none
// fir_pkg -- shared FSM type, default coefficients and width helpers for sym_fir_mac (rev 1.0)
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_t;

  localparam int DEF_TAPS = 12;
  localparam int NUM_COEF = DEF_TAPS / 2;
  localparam int COEF_AW  = $clog2(NUM_COEF);

  function automatic int acc_width(input int dw, input int cw, input int h);
    return dw + 1 + cw + $clog2(h);
  endfunction

  // Low-pass half-response; shorter filters take the leading entries.
  function automatic int coef_default(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 6;
      3:       return 10;
      4:       return 14;
      5:       return 16;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// fir_round_sat -- round-half-up, right-shift and unsigned saturation from AW to OW bits (rev 1.0)
module fir_round_sat #(
  parameter int AW    = 26,
  parameter int OW    = 10,
  parameter int SHIFT = 7
) (
  input  logic [AW-1:0] acc,
  output logic [OW-1:0] out_data,
  output logic          sat
);

  localparam logic [AW:0] RND  = (SHIFT == 0) ? '0 :
                                 ((AW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic [AW:0] MAXV = (AW+1)'({OW{1'b1}});

  logic [AW:0] sum;
  logic [AW:0] r;

  // One extra bit keeps the rounding add from wrapping at full scale.
  always_comb begin
    sum      = {1'b0, acc} + RND;
    r        = sum >> SHIFT;
    sat      = (r > MAXV);
    out_data = sat ? {OW{1'b1}} : r[OW-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/sym_fir_mac.sv
`default_nettype none
// sym_fir_mac -- folded symmetric FIR, one shared multiplier, valid/ready streaming (rev 1.0)
module sym_fir_mac
  import fir_pkg::*;
#(
  parameter int DW    = 10,
  parameter int CW    = 12,
  parameter int TAPS  = 12,
  parameter int SHIFT = 7,
  parameter int OW    = 10,
  parameter int AW    = acc_width(DW, CW, TAPS / 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DW-1:0]               in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OW-1:0]               out_data,
  output logic [AW-1:0]               acc_out,
  output logic                        sat,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS/2)-1:0]   coef_addr,
  input  logic [CW-1:0]               coef_wdata,
  output logic                        coef_ack
);

  localparam int HALF = TAPS / 2;
  localparam int KW   = $clog2(HALF);

  fir_state_t    state;
  fir_state_t    state_nxt;
  logic [DW-1:0] x    [TAPS];
  logic [CW-1:0] coef [HALF];
  logic [KW-1:0] k;
  logic [AW-1:0] acc;
  logic [KW:0]   idx_lo;
  logic [KW:0]   idx_hi;
  logic [DW:0]   pair;
  logic [AW-1:0] prod;
  logic [AW-1:0] acc_nxt;
  logic [OW-1:0] rs_data;
  logic          rs_sat;
  logic          accept;
  logic          mac_last;
  logic          coef_ok;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign mac_last = (state == ST_MAC) && (k == KW'(HALF - 1));
  assign coef_ok  = coef_we && (state == ST_IDLE) &&
                    ({1'b0, coef_addr} < (KW+1)'(HALF));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_MAC;
      ST_MAC:  if (mac_last)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Fold the mirrored taps before the single multiply.
  always_comb begin
    idx_lo  = {1'b0, k};
    idx_hi  = (KW+1)'(TAPS - 1) - idx_lo;
    pair    = {1'b0, x[idx_lo]} + {1'b0, x[idx_hi]};
    prod    = AW'(coef[k]) * AW'(pair);
    acc_nxt = acc + prod;
  end

  fir_round_sat #(
    .AW    (AW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc      (acc_nxt),
    .out_data (rs_data),
    .sat      (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      for (int i = 0; i < HALF; i++) coef[i] <= CW'(coef_default(i));
      k        <= '0;
      acc      <= '0;
      acc_out  <= '0;
      out_data <= '0;
      sat      <= 1'b0;
      coef_ack <= 1'b0;
    end else begin
      coef_ack <= coef_ok;
      if (coef_ok) coef[coef_addr] <= coef_wdata;
      if (accept) begin
        x[0] <= in_data;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        acc <= '0;
        k   <= '0;
      end
      if (state == ST_MAC) begin
        acc <= acc_nxt;
        k   <= k + KW'(1);
      end
      if (mac_last) begin
        acc_out  <= acc_nxt;
        out_data <= rs_data;
        sat      <= rs_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sym_fir_mac.sv
`default_nettype none
// tb_sym_fir_mac -- scoreboard bench: 12-tap instance for function, 8-tap instance for latency
module tb_sym_fir_mac;

  localparam int DW = 10, CW = 12, TAPS = 12, SHIFT = 7, OW = 10, HALF = 6, AW = 26;
  localparam int AW8 = DW + 1 + CW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [AW-1:0] acc_out;
  logic          sat;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic          coef_ack;

  logic           in_valid8 = 1'b0;
  logic [DW-1:0]  in_data8 = '0;
  logic           in_ready8, out_valid8, sat8, coef_ack8;
  logic [OW-1:0]  out_data8;
  logic [AW8-1:0] acc_out8;
  logic [1:0]     coef_addr8 = '0;
  logic [CW-1:0]  coef_wdata8 = '0;
  logic           coef_we8 = 1'b0;
  logic           out_ready8 = 1'b1;

  always #5 clk = ~clk;

  sym_fir_mac #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(SHIFT), .OW(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .acc_out(acc_out),
    .sat(sat), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_ack(coef_ack)
  );

  sym_fir_mac #(.DW(DW), .CW(CW), .TAPS(8), .SHIFT(SHIFT), .OW(OW)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .acc_out(acc_out8),
    .sat(sat8), .coef_we(coef_we8), .coef_addr(coef_addr8), .coef_wdata(coef_wdata8),
    .coef_ack(coef_ack8)
  );

  typedef struct {
    longint acc;
    longint data;
    longint sat;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint mx[TAPS];
  longint mcoef[HALF];
  longint obs_acc[$];
  longint obs_out[$];
  longint obs_sat[$];
  int     n_xfer = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) mx[i] = 0;
    mcoef = '{1, 2, 6, 10, 14, 16};
  endtask

  // Direct convolution with the mirrored full-length impulse response.
  task automatic model_accept(input int d);
    exp_t   e;
    longint a;
    longint r;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    a = 0;
    for (int j = 0; j < TAPS; j++)
      a += mcoef[(j < HALF) ? j : TAPS - 1 - j] * mx[j];
    r = (a + (1 << (SHIFT - 1))) >> SHIFT;
    e.acc  = a;
    e.sat  = (r > 1023) ? 1 : 0;
    e.data = (r > 1023) ? 1023 : r;
    sb_q.push_back(e);
  endtask

  task automatic send(input int d);
    int n;
    in_valid = 1'b1;
    in_data  = d[DW-1:0];
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      model_accept(d);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", sb_q.size(), 0);
    step();
  endtask

  task automatic coef_write(input int addr, input int data, input bit exp_ack);
    coef_we    = 1'b1;
    coef_addr  = addr[2:0];
    coef_wdata = data[CW-1:0];
    if (exp_ack) mcoef[addr] = data;
    step();
    coef_we = 1'b0;
    check("coef_ack", coef_ack, exp_ack);
    step();
    check("coef_ack_pulse", coef_ack, 0);
  endtask

  task automatic clear_obs();
    obs_acc.delete();
    obs_out.delete();
    obs_sat.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_xfer++;
      obs_acc.push_back(acc_out);
      obs_out.push_back(out_data);
      obs_sat.push_back(sat);
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_acc_out", acc_out, mon_e.acc);
        check("sb_out_data", out_data, mon_e.data);
        check("sb_sat", sat, mon_e.sat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    longint imp_acc[12] = '{100, 200, 600, 1000, 1400, 1600, 1600, 1400, 1000, 600, 200, 100};
    longint imp_out[6]  = '{1, 2, 5, 8, 11, 13};
    int     n;
    int     xf;
    bit     seen;
    logic [OW-1:0] held;

    model_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_sat", sat, 0);
    check("rst_coef_ack", coef_ack, 0);

    // Impulse response
    clear_obs();
    send(100);
    repeat (11) send(0);
    drain();
    for (int i = 0; i < 12; i++) check("imp_acc", (i < obs_acc.size()) ? obs_acc[i] : -1, imp_acc[i]);
    for (int i = 0; i < 6; i++)  check("imp_out", (i < obs_out.size()) ? obs_out[i] : -1, imp_out[i]);
    seen = 0;
    foreach (obs_sat[i]) if (obs_sat[i] != 0) seen = 1;
    check("imp_no_sat", seen, 0);

    // Full-scale step
    clear_obs();
    repeat (12) send(1023);
    drain();
    check("step_acc", obs_acc.size() > 0 ? obs_acc[$] : -1, 100254);
    check("step_out", obs_out.size() > 0 ? obs_out[$] : -1, 783);
    check("step_sat", obs_sat.size() > 0 ? obs_sat[$] : -1, 0);

    // Saturation with a large centre coefficient
    coef_write(5, 4095, 1'b1);
    clear_obs();
    repeat (12) send(1023);
    drain();
    check("sat_acc", obs_acc.size() > 0 ? obs_acc[$] : -1, 8445888);
    check("sat_out", obs_out.size() > 0 ? obs_out[$] : -1, 1023);
    check("sat_flag", obs_sat.size() > 0 ? obs_sat[$] : -1, 1);

    // Backpressure in DONE with a pending upstream sample
    out_ready = 1'b0;
    send(300);
    in_valid = 1'b1;
    in_data  = 10'd301;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    check("bp_reach_done", out_valid, 1);
    held = out_data;
    xf   = n_xfer;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    check("bp_no_xfer", n_xfer, xf);
    out_ready = 1'b1;
    step();
    check("bp_one_xfer", n_xfer, xf + 1);
    check("bp_ready_after", in_ready, 1);
    send(301);
    drain();

    // Latency, 12 taps and 8 taps
    send(7);
    n = 1;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("latency_12", n, 7);
    drain();
    in_valid8 = 1'b1;
    in_data8  = 10'd5;
    check("l8_in_ready", in_ready8, 1);
    step();
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 50) begin
      step();
      n++;
    end
    check("latency_8", n, 5);
    check("l8_acc_out", acc_out8, 5);

    // Coefficient writes that must be dropped
    send(200);
    coef_write(0, 4000, 1'b0);
    drain();
    coef_write(6, 123, 1'b0);
    send(200);
    drain();

    // Reset in the third MAC cycle
    send(500);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    model_reset();
    xf   = n_xfer;
    seen = 0;
    for (int i = 0; i < HALF + 3; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    check("rst_mid_no_valid", seen, 0);
    check("rst_mid_no_xfer", n_xfer, xf);
    clear_obs();
    send(100);
    repeat (5) send(0);
    drain();
    check("rst_line_cleared", obs_acc.size() > 0 ? obs_acc[0] : -1, 100);
    check("rst_coef_default", obs_acc.size() > 5 ? obs_acc[5] : -1, 1600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
